// File: rtl/sdram_host_adapter.sv
// Valid/ready request front end for sdram_controller: power-up wait, enable hold
// until the controller goes busy, issue timeout, and one response per request.
module sdram_host_adapter #(
  parameter int          HADDR_WIDTH      = 24,
  parameter logic [15:0] INIT_CYCLES      = 16'd200,
  parameter logic [7:0]  ISSUE_TIMEOUT    = 8'd32,
  parameter logic [1:0]  RD_CAPTURE_DELAY = 2'd1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [HADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]            req_wdata,
  output logic                   rsp_valid,
  output logic                   rsp_err,
  output logic [15:0]            rsp_rdata,
  output logic [HADDR_WIDTH-1:0] ctl_haddr,
  output logic [15:0]            ctl_data_input,
  output logic                   ctl_rd_enable,
  output logic                   ctl_wr_enable,
  input  logic [15:0]            ctl_data_output,
  input  logic                   ctl_busy
);

  localparam logic [2:0] S_WAIT_INIT = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_BUSY      = 3'd3;
  localparam logic [2:0] S_CAPTURE   = 3'd4;

  logic [2:0]  state;
  logic [15:0] init_cnt;
  logic [7:0]  tmo_cnt;
  logic [1:0]  cap_cnt;
  logic        we_q;
  logic        handshake;
  logic        done;

  // req_ready is only ever high in IDLE, so it alone qualifies the handshake.
  always_comb begin
    handshake = req_valid & req_ready;
    done      = 1'b0;
    if (state == S_BUSY && !ctl_busy && RD_CAPTURE_DELAY == 2'd0)
      done = 1'b1;
    if (state == S_CAPTURE && cap_cnt <= 2'd1)
      done = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_WAIT_INIT;
      init_cnt       <= INIT_CYCLES;
      tmo_cnt        <= '0;
      cap_cnt        <= '0;
      we_q           <= 1'b0;
      req_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_rdata      <= '0;
      ctl_haddr      <= '0;
      ctl_data_input <= '0;
      ctl_rd_enable  <= 1'b0;
      ctl_wr_enable  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        S_WAIT_INIT: begin
          if (init_cnt <= 16'd1) begin
            init_cnt  <= '0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            init_cnt <= init_cnt - 16'd1;
          end
        end
        S_IDLE: begin
          req_ready <= 1'b1;
          if (handshake) begin
            ctl_haddr <= req_addr;
            if (req_we)
              ctl_data_input <= req_wdata;
            we_q          <= req_we;
            ctl_wr_enable <= req_we;
            ctl_rd_enable <= ~req_we;
            req_ready     <= 1'b0;
            tmo_cnt       <= ISSUE_TIMEOUT;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Busy wins over a coinciding timeout: the controller has taken the request.
          if (ctl_busy) begin
            ctl_rd_enable <= 1'b0;
            ctl_wr_enable <= 1'b0;
            state         <= S_BUSY;
          end else if (tmo_cnt <= 8'd1) begin
            tmo_cnt       <= '0;
            ctl_rd_enable <= 1'b0;
            ctl_wr_enable <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_err       <= 1'b1;
            state         <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - 8'd1;
          end
        end
        S_BUSY: begin
          if (!ctl_busy && RD_CAPTURE_DELAY != 2'd0) begin
            cap_cnt <= RD_CAPTURE_DELAY;
            state   <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (cap_cnt > 2'd1)
            cap_cnt <= cap_cnt - 2'd1;
        end
        default: begin
          init_cnt <= INIT_CYCLES;
          state    <= S_WAIT_INIT;
        end
      endcase

      if (done) begin
        if (!we_q)
          rsp_rdata <= ctl_data_output;
        rsp_valid <= 1'b1;
        cap_cnt   <= '0;
        state     <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_sdram_host_adapter.sv
// Directed bench for sdram_host_adapter: table of single transactions against a
// cycle-level controller busy model, plus reset/init and mid-operation reset sequences.
module tb_sdram_host_adapter;

  localparam int AW   = 24;
  localparam int D    = 1;
  localparam int INIT = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [15:0]   req_wdata;
  logic          rsp_valid, rsp_err;
  logic [15:0]   rsp_rdata;
  logic [AW-1:0] ctl_haddr;
  logic [15:0]   ctl_data_input;
  logic          ctl_rd_enable, ctl_wr_enable;
  logic [15:0]   ctl_data_output;
  logic          ctl_busy;

  always #5 clk = ~clk;

  sdram_host_adapter #(
    .HADDR_WIDTH      (AW),
    .INIT_CYCLES      (16'd20),
    .ISSUE_TIMEOUT    (8'd16),
    .RD_CAPTURE_DELAY (2'd1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_err         (rsp_err),
    .rsp_rdata       (rsp_rdata),
    .ctl_haddr       (ctl_haddr),
    .ctl_data_input  (ctl_data_input),
    .ctl_rd_enable   (ctl_rd_enable),
    .ctl_wr_enable   (ctl_wr_enable),
    .ctl_data_output (ctl_data_output),
    .ctl_busy        (ctl_busy)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic [15:0]   rdval;
    int            lat;      // edge (after handshake) busy is first sampled high; 0 = never
    int            len;      // edges busy stays high
    int            exp_en;   // cycles the enable is high
    int            exp_rsp;  // cycle index (after edge N) rsp_valid is high
    logic          exp_err;
  } vec_t;

  vec_t        vecs [9];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_rdata;
  logic [15:0] exp_din;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        return;
      end
    end
    chk("ready_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          en_cnt, other_cnt, rsp_cnt, rsp_at, rdy_at, m;
    logic        err_at;
    logic [15:0] rdata_at;
    logic [AW-1:0] haddr_at;
    bit          ok;
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    ctl_busy = 1'b0; ctl_data_output = ~v.rdval;
    @(posedge clk); #1;
    // Keep valid asserted with different contents: must be ignored outside IDLE.
    req_we = ~v.we; req_addr = ~v.addr; req_wdata = ~v.wdata;
    if (v.we) exp_din = v.wdata;
    m = (v.lat == 0) ? -1 : v.lat + v.len;
    en_cnt = 0; other_cnt = 0; rsp_cnt = 0; rsp_at = -1; rdy_at = -1;
    err_at = 1'b0; rdata_at = '0; haddr_at = '0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk($sformatf("v%0d_haddr", idx), 32'(ctl_haddr), 32'(v.addr));
        chk($sformatf("v%0d_din", idx), 32'(ctl_data_input), 32'(exp_din));
      end
      if (v.we ? ctl_wr_enable : ctl_rd_enable) en_cnt++;
      if (v.we ? ctl_rd_enable : ctl_wr_enable) other_cnt++;
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_at < 0) begin
          rsp_at = c; err_at = rsp_err; rdata_at = rsp_rdata; haddr_at = ctl_haddr;
        end
      end
      if (req_ready && rdy_at < 0) rdy_at = c;
      if (c >= v.exp_rsp) req_valid = 1'b0;
      ctl_busy = (v.lat != 0) && (c + 1 >= v.lat) && (c + 1 < v.lat + v.len);
      ctl_data_output = (m >= 0 && c + 1 >= m + D) ? v.rdval : ~v.rdval;
    end
    ctl_busy = 1'b0;
    if (!v.we && !v.exp_err) exp_rdata = v.rdval;
    chk($sformatf("v%0d_en_cycles", idx), 32'(en_cnt), 32'(v.exp_en));
    chk($sformatf("v%0d_other_en", idx), 32'(other_cnt), 32'd0);
    chk($sformatf("v%0d_rsp_count", idx), 32'(rsp_cnt), 32'd1);
    chk($sformatf("v%0d_rsp_cycle", idx), 32'(rsp_at), 32'(v.exp_rsp));
    chk($sformatf("v%0d_rsp_err", idx), 32'(err_at), 32'(v.exp_err));
    chk($sformatf("v%0d_rsp_rdata", idx), 32'(rdata_at), 32'(exp_rdata));
    chk($sformatf("v%0d_ready_cycle", idx), 32'(rdy_at), 32'(v.exp_rsp + 1));
    chk($sformatf("v%0d_haddr_stable", idx), 32'(haddr_at), 32'(v.addr));
  endtask

  task automatic count_init(input string nm);
    int first, rsp_seen;
    first = -1; rsp_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
      if (req_ready) begin
        first = i;
        break;
      end
    end
    chk({nm, "_ready_after"}, 32'(first), 32'(INIT));
    chk({nm, "_no_rsp"}, 32'(rsp_seen), 32'd0);
  endtask

  task automatic reset_mid(input string nm, input int rst_c, input int lat, input int len);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h000321; req_wdata = 16'h4444;
    ctl_busy = 1'b0; ctl_data_output = 16'hDEAD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 0; c < rst_c; c++) begin
      @(negedge clk);
      chk($sformatf("%s_pre_en%0d", nm, c), 32'(ctl_rd_enable), 32'(lat == 0 || c < lat));
      ctl_busy = (lat != 0) && (c + 1 >= lat) && (c + 1 < lat + len);
    end
    rst = 1'b1; ctl_busy = 1'b0;
    @(negedge clk);
    chk({nm, "_outs"}, {28'd0, ctl_rd_enable, ctl_wr_enable, rsp_valid, req_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rdata = '0; exp_din = '0;
    count_init(nm);
    chk({nm, "_rdata_clr"}, 32'(rsp_rdata), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 24'h012345, 16'hBEEF, 16'h0000,  2, 6,  2,  9, 1'b0};
    vecs[1] = '{1'b0, 24'h000100, 16'h0000, 16'hA5C3,  2, 5,  2,  8, 1'b0};
    vecs[2] = '{1'b0, 24'h7FFFFF, 16'h1111, 16'h1234, 12, 4, 12, 17, 1'b0};
    vecs[3] = '{1'b1, 24'hFFFFFF, 16'h0000, 16'h0000, 12, 3, 12, 16, 1'b0};
    vecs[4] = '{1'b0, 24'h000ABC, 16'h2222, 16'h9999,  0, 0, 16, 16, 1'b1};
    vecs[5] = '{1'b0, 24'h0055AA, 16'h3333, 16'h5A5A,  3, 1,  3,  5, 1'b0};
    vecs[6] = '{1'b1, 24'h00F00F, 16'h7777, 16'h0000,  0, 0, 16, 16, 1'b1};
    vecs[7] = '{1'b1, 24'h123456, 16'hC0DE, 16'h0000, 15, 2, 15, 18, 1'b0};
    vecs[8] = '{1'b1, 24'h654321, 16'hF00D, 16'h0000, 16, 2, 16, 19, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    ctl_busy = 1'b0; ctl_data_output = '0;
    exp_rdata = '0; exp_din = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl_outs", {27'd0, req_ready, rsp_valid, rsp_err, ctl_rd_enable, ctl_wr_enable}, 32'd0);
    chk("reset_rdata", 32'(rsp_rdata), 32'd0);
    chk("reset_haddr", 32'(ctl_haddr), 32'd0);
    chk("reset_din", 32'(ctl_data_input), 32'd0);
    rst = 1'b0;
    count_init("init");

    for (int i = 0; i < 9; i++)
      run_vec(vecs[i], i);

    reset_mid("rst_busy", 4, 2, 10);
    reset_mid("rst_issue", 1, 0, 0);
    run_vec(vecs[1], 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
